// File: rtl/mips_pkg.sv
// Shared decode constants and record types for the p4 single-cycle control unit.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;

    localparam logic [4:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
    } instr_flags_t;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] index;
    } instr_fields_t;

endpackage

// File: rtl/mips_control_if.sv
// Bus between the control unit and the GF/ALU/DM/PC blocks around it.
interface mips_control_if;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] ReadGF1;
    logic [31:0] ReadGF2;
    logic [31:0] ReadDM;
    logic [31:0] ALUresult;
    logic        Jumpsign;
    logic [31:0] JumpAddr;
    logic        WEgf;
    logic [4:0]  WriteGFadd;
    logic [31:0] WriteGFdata;
    logic [4:0]  readGFadd1;
    logic [4:0]  readGFadd2;
    logic        WEdm;
    logic [31:0] WriteDMadd;
    logic [31:0] WriteDMdata;
    logic [31:0] readDMadd;
    logic [3:0]  ALUopcode;
    logic [31:0] ALUinput1;
    logic [31:0] ALUinput2;

    modport master (
        input  Instr, PC, ReadGF1, ReadGF2, ReadDM, ALUresult,
        output Jumpsign, JumpAddr, WEgf, WriteGFadd, WriteGFdata,
               readGFadd1, readGFadd2, WEdm, WriteDMadd, WriteDMdata,
               readDMadd, ALUopcode, ALUinput1, ALUinput2
    );

    modport slave (
        output Instr, PC, ReadGF1, ReadGF2, ReadDM, ALUresult,
        input  Jumpsign, JumpAddr, WEgf, WriteGFadd, WriteGFdata,
               readGFadd1, readGFadd2, WEdm, WriteDMadd, WriteDMdata,
               readDMadd, ALUopcode, ALUinput1, ALUinput2
    );
endinterface

// File: rtl/mips_decode.sv
// Splits an instruction word into its fields and a one-hot flag per supported instruction.
module mips_decode
    import mips_pkg::*;
(
    input  logic [31:0]   i_instr,
    output instr_flags_t  o_flags,
    output instr_fields_t o_fields
);

    logic [5:0] w_op;
    logic [5:0] w_funct;

    assign w_op    = i_instr[31:26];
    assign w_funct = i_instr[5:0];

    assign o_fields.rs    = i_instr[25:21];
    assign o_fields.rt    = i_instr[20:16];
    assign o_fields.rd    = i_instr[15:11];
    assign o_fields.imm   = i_instr[15:0];
    assign o_fields.index = i_instr[25:0];

    // Unrecognised encodings leave every flag clear and so decode as a nop.
    always_comb begin
        o_flags = '0;
        case (w_op)
            OP_RTYPE: begin
                o_flags.addu = (w_funct == FN_ADDU);
                o_flags.subu = (w_funct == FN_SUBU);
                o_flags.jr   = (w_funct == FN_JR);
            end
            OP_ORI:  o_flags.ori = 1'b1;
            OP_LUI:  o_flags.lui = 1'b1;
            OP_LW:   o_flags.lw  = 1'b1;
            OP_SW:   o_flags.sw  = 1'b1;
            OP_BEQ:  o_flags.beq = 1'b1;
            OP_J:    o_flags.j   = 1'b1;
            OP_JAL:  o_flags.jal = 1'b1;
            default: o_flags = '0;
        endcase
    end

endmodule

// File: rtl/mips_control.sv
// Single-cycle control: steers GF, ALU, DM and PC from the decoded instruction;
// a registered active flag holds off every side effect around reset.
module mips_control
    import mips_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    mips_control_if.master bus
);

    function automatic logic signed [31:0] sext16(input logic [15:0] v);
        return $signed({{16{v[15]}}, v});
    endfunction

    function automatic logic signed [31:0] branch_off(input logic [15:0] v);
        return $signed({{14{v[15]}}, v, 2'b00});
    endfunction

    instr_flags_t  w_flags;
    instr_fields_t w_fields;

    logic        r_active;
    logic [31:0] w_pc4;
    logic        w_jump;
    logic [31:0] w_jaddr;
    logic        w_we_gf;
    logic [4:0]  w_gf_wadd;
    logic [31:0] w_gf_wdata;
    logic        w_we_dm;
    logic [31:0] w_dm_wadd;
    logic [31:0] w_dm_wdata;
    logic [31:0] w_dm_radd;
    logic [3:0]  w_aluop;
    logic [31:0] w_in1;
    logic [31:0] w_in2;

    mips_decode u_decode (
        .i_instr  (bus.Instr),
        .o_flags  (w_flags),
        .o_fields (w_fields)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) r_active <= 1'b0;
        else          r_active <= 1'b1;
    end

    assign w_pc4 = bus.PC + 32'd4;

    always_comb begin
        w_jump     = 1'b0;
        w_jaddr    = '0;
        w_we_gf    = 1'b0;
        w_gf_wadd  = '0;
        w_gf_wdata = '0;
        w_we_dm    = 1'b0;
        w_dm_wadd  = '0;
        w_dm_wdata = '0;
        w_dm_radd  = '0;
        w_aluop    = ALU_ADD;
        w_in1      = '0;
        w_in2      = '0;
        if (w_flags.addu || w_flags.subu) begin
            w_aluop    = w_flags.subu ? ALU_SUB : ALU_ADD;
            w_in1      = bus.ReadGF1;
            w_in2      = bus.ReadGF2;
            w_we_gf    = 1'b1;
            w_gf_wadd  = w_fields.rd;
            w_gf_wdata = bus.ALUresult;
        end else if (w_flags.jr) begin
            w_jump  = 1'b1;
            w_jaddr = bus.ReadGF1;
        end else if (w_flags.ori) begin
            w_aluop    = ALU_OR;
            w_in1      = bus.ReadGF1;
            w_in2      = {16'h0, w_fields.imm};
            w_we_gf    = 1'b1;
            w_gf_wadd  = w_fields.rt;
            w_gf_wdata = bus.ALUresult;
        end else if (w_flags.lui) begin
            w_in2      = {w_fields.imm, 16'h0};
            w_we_gf    = 1'b1;
            w_gf_wadd  = w_fields.rt;
            w_gf_wdata = bus.ALUresult;
        end else if (w_flags.lw) begin
            w_in1      = bus.ReadGF1;
            w_in2      = $unsigned(sext16(w_fields.imm));
            w_dm_radd  = bus.ALUresult;
            w_we_gf    = 1'b1;
            w_gf_wadd  = w_fields.rt;
            w_gf_wdata = bus.ReadDM;
        end else if (w_flags.sw) begin
            w_in1      = bus.ReadGF1;
            w_in2      = $unsigned(sext16(w_fields.imm));
            w_we_dm    = 1'b1;
            w_dm_wadd  = bus.ALUresult;
            w_dm_wdata = bus.ReadGF2;
        end else if (w_flags.beq) begin
            // Compare and target are local so the ALU stays free of branch work.
            w_jump  = (bus.ReadGF1 == bus.ReadGF2);
            w_jaddr = w_pc4 + $unsigned(branch_off(w_fields.imm));
        end else if (w_flags.j || w_flags.jal) begin
            w_jump  = 1'b1;
            w_jaddr = {w_pc4[31:28], w_fields.index, 2'b00};
            if (w_flags.jal) begin
                w_we_gf    = 1'b1;
                w_gf_wadd  = REG_RA;
                w_gf_wdata = w_pc4;
            end
        end
    end

    assign bus.readGFadd1  = w_fields.rs;
    assign bus.readGFadd2  = w_fields.rt;
    assign bus.Jumpsign    = w_jump & r_active;
    assign bus.JumpAddr    = w_jaddr;
    // Register 0 is hardwired, so a write aimed at it is suppressed here.
    assign bus.WEgf        = w_we_gf & (w_gf_wadd != 5'd0) & r_active;
    assign bus.WriteGFadd  = w_gf_wadd;
    assign bus.WriteGFdata = w_gf_wdata;
    assign bus.WEdm        = w_we_dm & r_active;
    assign bus.WriteDMadd  = w_dm_wadd;
    assign bus.WriteDMdata = w_dm_wdata;
    assign bus.readDMadd   = w_dm_radd;
    assign bus.ALUopcode   = w_aluop;
    assign bus.ALUinput1   = w_in1;
    assign bus.ALUinput2   = w_in2;

endmodule

// File: tb/tb_mips_control.sv
// Randomised and directed checks of mips_control against an instruction-level reference model.
module tb_mips_control;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;
    bit   m_active;

    mips_control_if bus ();

    mips_control dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) m_active <= reset_n;

    typedef struct {
        logic        jump;
        logic [31:0] jaddr;
        logic        wegf;
        logic [4:0]  wadd;
        logic [31:0] wdata;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        wedm;
        logic [31:0] dmwadd;
        logic [31:0] dmwdata;
        logic [31:0] dmradd;
        logic [3:0]  aluop;
        logic [31:0] in1;
        logic [31:0] in2;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] g1, input logic [31:0] g2,
                                   input logic [31:0] dm, input logic [31:0] alu, input bit act);
        exp_t e;
        int   simm;
        bit   wr;
        logic [5:0]  op    = ins[31:26];
        logic [5:0]  fn    = ins[5:0];
        logic [15:0] imm   = ins[15:0];
        logic [31:0] pc4   = pc + 4;
        e = '{default: '0};
        simm = $signed(imm);
        e.r1 = ins[25:21];
        e.r2 = ins[20:16];
        wr = 0;
        if (op == 6'd0 && (fn == 6'h21 || fn == 6'h23)) begin
            e.aluop = (fn == 6'h23) ? 4'd1 : 4'd0;
            e.in1 = g1; e.in2 = g2; wr = 1; e.wadd = ins[15:11]; e.wdata = alu;
        end else if (op == 6'd0 && fn == 6'h08) begin
            e.jump = 1; e.jaddr = g1;
        end else if (op == 6'h0D) begin
            e.aluop = 2; e.in1 = g1; e.in2 = 32'(imm); wr = 1; e.wadd = ins[20:16]; e.wdata = alu;
        end else if (op == 6'h0F) begin
            e.in2 = 32'(imm) * 65536; wr = 1; e.wadd = ins[20:16]; e.wdata = alu;
        end else if (op == 6'h23) begin
            e.in1 = g1; e.in2 = simm; e.dmradd = alu; wr = 1; e.wadd = ins[20:16]; e.wdata = dm;
        end else if (op == 6'h2B) begin
            e.in1 = g1; e.in2 = simm; e.wedm = 1; e.dmwadd = alu; e.dmwdata = g2;
        end else if (op == 6'h04) begin
            e.jump = (g1 == g2); e.jaddr = pc4 + simm * 4;
        end else if (op == 6'h02 || op == 6'h03) begin
            e.jump = 1;
            e.jaddr = (pc4 & 32'hF000_0000) + 32'(ins[25:0]) * 4;
            if (op == 6'h03) begin
                wr = 1; e.wadd = 31; e.wdata = pc4;
            end
        end
        e.wegf = wr && (e.wadd != 0) && act;
        e.wedm = e.wedm && act;
        e.jump = e.jump && act;
        return e;
    endfunction

    // Drives one instruction with its read data and compares every output to the model.
    task automatic apply(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] g1,
                         input logic [31:0] g2, input logic [31:0] dm, input logic [31:0] alu,
                         input bit chk_jaddr);
        exp_t e;
        bus.Instr = ins; bus.PC = pc; bus.ReadGF1 = g1; bus.ReadGF2 = g2;
        bus.ReadDM = dm; bus.ALUresult = alu;
        #1;
        e = model(ins, pc, g1, g2, dm, alu, m_active);
        chk("Jumpsign", 32'(bus.Jumpsign), 32'(e.jump));
        if (chk_jaddr) chk("JumpAddr", bus.JumpAddr, e.jaddr);
        chk("WEgf", 32'(bus.WEgf), 32'(e.wegf));
        chk("WriteGFadd", 32'(bus.WriteGFadd), 32'(e.wadd));
        chk("WriteGFdata", bus.WriteGFdata, e.wdata);
        chk("readGFadd1", 32'(bus.readGFadd1), 32'(e.r1));
        chk("readGFadd2", 32'(bus.readGFadd2), 32'(e.r2));
        chk("WEdm", 32'(bus.WEdm), 32'(e.wedm));
        chk("WriteDMadd", bus.WriteDMadd, e.dmwadd);
        chk("WriteDMdata", bus.WriteDMdata, e.dmwdata);
        chk("readDMadd", bus.readDMadd, e.dmradd);
        chk("ALUopcode", 32'(bus.ALUopcode), 32'(e.aluop));
        chk("ALUinput1", bus.ALUinput1, e.in1);
        chk("ALUinput2", bus.ALUinput2, e.in2);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs  = 5'($urandom);
        logic [4:0]  rt  = 5'($urandom);
        logic [4:0]  rd  = 5'($urandom);
        logic [15:0] imm = 16'($urandom);
        case ($urandom_range(0, 10))
            0:  return {6'h00, rs, rt, rd, 5'($urandom), 6'h21};
            1:  return {6'h00, rs, rt, rd, 5'($urandom), 6'h23};
            2:  return {6'h00, rs, 15'h0, 6'h08};
            3:  return {6'h0D, rs, rt, imm};
            4:  return {6'h0F, rs, rt, imm};
            5:  return {6'h23, rs, rt, imm};
            6:  return {6'h2B, rs, rt, imm};
            7:  return {6'h04, rs, rt, imm};
            8:  return {6'h02, 26'($urandom)};
            9:  return {6'h03, 26'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    localparam logic [31:0] SW_I = {6'h2B, 5'd2, 5'd3, 16'h0010};

    initial begin
        logic [31:0] g1;
        logic [31:0] g2;
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0;
        bus.Instr = SW_I; bus.PC = '0; bus.ReadGF1 = '0; bus.ReadGF2 = '0;
        bus.ReadDM = '0; bus.ALUresult = '0;

        repeat (2) begin
            @(negedge clk);
            apply(SW_I, 32'h3000, 32'h10, 32'h55, 32'h0, 32'h20, 1);
            chk("rst_WEdm", 32'(bus.WEdm), 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        apply(SW_I, 32'h3000, 32'h10, 32'h55, 32'h0, 32'h20, 1);
        chk("rel_WEdm_pre", 32'(bus.WEdm), 32'd0);
        @(negedge clk);
        apply(SW_I, 32'h3000, 32'h10, 32'h55, 32'h0, 32'h20, 1);
        chk("rel_WEdm_post", 32'(bus.WEdm), 32'd1);

        @(negedge clk);
        apply(32'h0000_0021, 32'h3000, 32'h9, 32'h9, 32'h0, 32'h12, 1);
        chk("nop_addu_WEgf", 32'(bus.WEgf), 32'd0);
        chk("nop_addu_wadd", 32'(bus.WriteGFadd), 32'd0);
        chk("nop_addu_op", 32'(bus.ALUopcode), 32'd0);
        chk("nop_addu_jump", 32'(bus.Jumpsign), 32'd0);

        @(negedge clk);
        apply({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 32'h3000, 32'd5, 32'd7, 32'h0, 32'd12, 1);
        chk("addu_r1", 32'(bus.readGFadd1), 32'd1);
        chk("addu_r2", 32'(bus.readGFadd2), 32'd2);
        chk("addu_WEgf", 32'(bus.WEgf), 32'd1);
        chk("addu_wadd", 32'(bus.WriteGFadd), 32'd3);
        chk("addu_wdata", bus.WriteGFdata, 32'd12);

        @(negedge clk);
        apply({6'h23, 5'd5, 5'd4, 16'hFFFC}, 32'h3000, 32'h100, 32'h0, 32'hDEAD, 32'hFC, 1);
        chk("lw_in2", bus.ALUinput2, 32'hFFFF_FFFC);
        chk("lw_radd", bus.readDMadd, 32'hFC);
        chk("lw_wdata", bus.WriteGFdata, 32'hDEAD);
        chk("lw_WEgf", 32'(bus.WEgf), 32'd1);

        @(negedge clk);
        apply({6'h04, 5'd1, 5'd2, 16'hFFFF}, 32'h3010, 32'h77, 32'h77, 32'h0, 32'h0, 1);
        chk("beq_eq_jump", 32'(bus.Jumpsign), 32'd1);
        chk("beq_eq_addr", bus.JumpAddr, 32'h3010);
        @(negedge clk);
        apply({6'h04, 5'd1, 5'd2, 16'hFFFF}, 32'h3010, 32'h77, 32'h78, 32'h0, 32'h0, 0);
        chk("beq_ne_jump", 32'(bus.Jumpsign), 32'd0);

        @(negedge clk);
        apply({6'h03, 26'h0C00}, 32'h3000, 32'h1, 32'h2, 32'h0, 32'h0, 1);
        chk("jal_addr", bus.JumpAddr, 32'h3000);
        chk("jal_wadd", 32'(bus.WriteGFadd), 32'd31);
        chk("jal_wdata", bus.WriteGFdata, 32'h3004);
        chk("jal_WEgf", 32'(bus.WEgf), 32'd1);

        @(negedge clk);
        apply({6'h0F, 5'd0, 5'd1, 16'h1234}, 32'h3000, 32'hAA, 32'hBB, 32'h0, 32'h1234_0000, 1);
        chk("lui_in2", bus.ALUinput2, 32'h1234_0000);
        chk("lui_in1", bus.ALUinput1, 32'd0);

        // Mid-run reset: enables stay up until the next clock edge.
        @(negedge clk);
        reset_n = 1'b0;
        apply(SW_I, 32'h3000, 32'h10, 32'h55, 32'h0, 32'h20, 1);
        chk("midrst_WEdm_pre", 32'(bus.WEdm), 32'd1);
        @(negedge clk);
        apply(SW_I, 32'h3000, 32'h10, 32'h55, 32'h0, 32'h20, 1);
        chk("midrst_WEdm_post", 32'(bus.WEdm), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            g1 = $urandom;
            g2 = ($urandom_range(0, 1) == 1) ? g1 : $urandom;
            apply(rand_instr(), {$urandom, 2'b00} >> 2 << 2, g1, g2, $urandom, $urandom, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
